lsu_mem_port: RTL and testbench

//  Multi-cycle load/store unit that executes the load/store the control unit decodes.

---
 rtl/lsu_mem_port_if.sv | 23 ++
 rtl/lsu_mem_port.sv | 169 ++++++++++++++++
 tb/tb_lsu_mem_port.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_port_if.sv
// Data-memory bus between the LSU (master) and memory (slave): one valid/ready request
// channel and one response channel with no backpressure.
interface lsu_mem_port_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        mem_resp_err;

  modport master (
    output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
  );

  modport slave (
    input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
  );
endinterface

// File: rtl/lsu_mem_port.sv
// RV32I load/store unit: one bus transaction per instruction, 4 cycles minimum (IDLE,REQ,RESP,DONE);
// stalls the core via busy while the request waits on mem_req_ready or the response is pending.
module lsu_mem_port #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic [1:0]  err,
  lsu_mem_port_if.master mem
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        we_q, we_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rdv_q, rdv_d;
  logic [1:0]  err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        req;
  logic        misalign;
  logic        illegal;
  logic        timeout;
  logic [31:0] shifted;
  logic [31:0] ext;

  assign req      = load | store;
  assign misalign = ((funct3[1:0] == 2'b01) & addr[0]) | ((funct3[1:0] == 2'b10) & (|addr[1:0]));
  assign illegal  = (load & store)
                  | (load & ((funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111)))
                  | (store & (funct3 >= 3'b011))
                  | misalign;
  // Last REQ/RESP cycle before the abort; a response or handshake in it still wins.
  assign timeout  = (cnt_q >= CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      we_q    <= 1'b0;
      wstrb_q <= 4'b0000;
      wdata_q <= 32'h0;
      addr_q  <= 32'h0;
      rdata_q <= 32'h0;
      rdv_q   <= 1'b0;
      err_q   <= 2'b00;
      cnt_q   <= 8'h0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      we_q    <= we_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      rdv_q   <= rdv_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = illegal ? DONE : REQ;
      REQ:     if (mem.mem_req_ready) state_d = RESP;
               else if (timeout) state_d = DONE;
      RESP:    if (mem.mem_resp_valid || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    f3_d    = f3_q;
    off_d   = off_q;
    we_d    = we_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    rdv_d   = 1'b0;
    err_d   = 2'b00;
    cnt_d   = ((state_q == REQ) || (state_q == RESP)) ? cnt_q + 8'd1 : 8'd0;

    shifted = mem.mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ext = {24'h0, shifted[7:0]};
      3'b101:  ext = {16'h0, shifted[15:0]};
      default: ext = shifted;
    endcase

    case (state_q)
      IDLE: begin
        if (req) begin
          f3_d   = funct3;
          off_d  = addr[1:0];
          we_d   = store;
          addr_d = {addr[31:2], 2'b00};
          case (funct3[1:0])
            2'b00: begin
              wstrb_d = 4'b0001 << addr[1:0];
              wdata_d = {4{wdata[7:0]}};
            end
            2'b01: begin
              wstrb_d = addr[1] ? 4'b1100 : 4'b0011;
              wdata_d = {2{wdata[15:0]}};
            end
            default: begin
              wstrb_d = 4'b1111;
              wdata_d = wdata;
            end
          endcase
          if (!store) wstrb_d = 4'b0000;
          if (illegal) err_d = 2'b01;
        end
      end
      REQ: begin
        if (!mem.mem_req_ready && timeout) err_d = 2'b11;
      end
      RESP: begin
        if (mem.mem_resp_valid) begin
          if (mem.mem_resp_err) begin
            err_d = 2'b10;
          end else if (!we_q) begin
            rdata_d = ext;
            rdv_d   = 1'b1;
          end
        end else if (timeout) begin
          err_d = 2'b11;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy              = ((state_q == IDLE) && req) || (state_q == REQ) || (state_q == RESP);
    rdata             = rdata_q;
    rdata_valid       = rdv_q;
    err               = err_q;
    mem.mem_req_valid = (state_q == REQ);
    mem.mem_we        = we_q;
    mem.mem_addr      = addr_q;
    mem.mem_wdata     = wdata_q;
    mem.mem_wstrb     = wstrb_q;
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
module tb_lsu_mem_port;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load, store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        busy;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic [1:0]  err;
  int          total = 0;
  int          bad = 0;

  lsu_mem_port_if bus();

  lsu_mem_port #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .store(store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .rdata(rdata),
    .rdata_valid(rdata_valid), .err(err), .mem(bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives one instruction from IDLE to the IDLE after DONE, playing the memory side.
  // rdy_dly/rsp_dly < 0 means the memory never accepts / never responds.
  task automatic run_access(input string nm, input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdw,
                            input int rdy_dly, input int rsp_dly, input logic rerr);
    int          sz, off, cyc, req_cyc, rsp_cyc, exp_lat;
    bit          ill, hs, done, to_exp;
    logic [3:0]  e_strb;
    logic [31:0] e_wd, e_rd;
    logic [1:0]  e_err;
    logic        e_rv;
    longint      v;

    sz  = 1 << f3[1:0];
    off = int'(a[1:0]);
    ill = (ld && st) || (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
       || (st && f3 > 3'd2) || ((off % sz) != 0);
    e_strb = st ? 4'(((1 << sz) - 1) << off) : 4'b0000;
    for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = wd[8*(i % sz) +: 8];
    v = longint'(rdw >> (8 * off));
    if (sz < 4) begin
      v = v & ((64'sd1 << (8 * sz)) - 1);
      if (!f3[2] && v[8*sz-1]) v = v - (64'sd1 << (8 * sz));
    end
    e_rd = v[31:0];
    to_exp = 1'b0;
    if (ill) begin
      e_err = 2'b01; exp_lat = 1;
    end else if (rdy_dly < 0 || rsp_dly < 0) begin
      e_err = 2'b11; exp_lat = TO + 1; to_exp = 1'b1;
    end else begin
      e_err = rerr ? 2'b10 : 2'b00; exp_lat = rdy_dly + 2 + rsp_dly;
    end
    e_rv = ld && !ill && !to_exp && !rerr;

    load = ld; store = st; funct3 = f3; addr = a; wdata = wd;
    #1;
    chk({nm, ":busy_idle"}, busy, 1);
    cyc = 0; req_cyc = 0; rsp_cyc = 0; hs = 0; done = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_err = 1'b0;
      bus.mem_rdata = $urandom;
      cyc++;
      #1;
      if (!busy) begin
        done = 1;
        chk({nm, ":latency"}, cyc, exp_lat);
        chk({nm, ":err"}, err, e_err);
        chk({nm, ":rdata_valid"}, rdata_valid, e_rv);
        if (e_rv) chk({nm, ":rdata"}, rdata, e_rd);
        chk({nm, ":req_valid_done"}, bus.mem_req_valid, 0);
        if (ill || rdy_dly < 0) chk({nm, ":req_cycles"}, req_cyc, ill ? 0 : TO);
        load = 1'b0; store = 1'b0;
        if (to_exp) begin
          bus.mem_resp_valid = 1'b1; bus.mem_resp_err = 1'b1; bus.mem_rdata = $urandom;
        end
      end else if (bus.mem_req_valid) begin
        chk({nm, ":mem_addr"}, bus.mem_addr, a & 32'hFFFF_FFFC);
        chk({nm, ":mem_we"}, bus.mem_we, st);
        chk({nm, ":mem_wstrb"}, bus.mem_wstrb, e_strb);
        if (st) chk({nm, ":mem_wdata"}, bus.mem_wdata, e_wd);
        if (rdy_dly >= 0 && req_cyc == rdy_dly) begin
          bus.mem_req_ready = 1'b1; hs = 1;
        end
        req_cyc++;
      end else if (hs) begin
        rsp_cyc++;
        if (rsp_cyc == rsp_dly) begin
          bus.mem_resp_valid = 1'b1; bus.mem_rdata = rdw; bus.mem_resp_err = rerr;
        end
      end
    end
    if (!done) begin
      chk({nm, ":done_reached"}, 0, 1);
      load = 1'b0; store = 1'b0;
    end
    @(negedge clk);
    bus.mem_resp_valid = 1'b0; bus.mem_resp_err = 1'b0;
    #1;
    chk({nm, ":busy_after"}, busy, 0);
    chk({nm, ":err_after"}, err, 0);
    chk({nm, ":rdv_after"}, rdata_valid, 0);
    chk({nm, ":req_after"}, bus.mem_req_valid, 0);
    if (e_rv) chk({nm, ":rdata_hold"}, rdata, e_rd);
  endtask

  initial begin
    int          kind, mode, rdy, rsp;
    logic        ld, st, rerr;
    logic [2:0]  f3;
    logic [31:0] a;

    rst_n = 1'b0; load = 1'b0; store = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_rdata = 32'h0; bus.mem_resp_err = 1'b0;
    #1;
    chk("rst:busy", busy, 0);
    chk("rst:rdata", rdata, 0);
    chk("rst:rdata_valid", rdata_valid, 0);
    chk("rst:err", err, 0);
    chk("rst:req_valid", bus.mem_req_valid, 0);
    chk("rst:wstrb", bus.mem_wstrb, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_access("lw",     1, 0, 3'b010, 32'h8000_0010, 32'h0,         32'hDEAD_BEEF, 0, 1, 0);
    run_access("lb",     1, 0, 3'b000, 32'h8000_0003, 32'h0,         32'h80FF_7F01, 0, 1, 0);
    run_access("lbu",    1, 0, 3'b100, 32'h8000_0003, 32'h0,         32'h80FF_7F01, 1, 2, 0);
    run_access("sh",     0, 1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'h0,         0, 1, 0);
    run_access("sb",     0, 1, 3'b000, 32'h8000_0001, 32'h0000_00A5, 32'h0,         2, 1, 0);
    run_access("lw_mis", 1, 0, 3'b010, 32'h8000_0002, 32'h0,         32'h0,         0, 1, 0);
    run_access("ld_st",  1, 1, 3'b010, 32'h8000_0000, 32'h0,         32'h0,         0, 1, 0);
    run_access("to_req", 1, 0, 3'b010, 32'h8000_0040, 32'h0,         32'h0,        -1, 1, 0);
    run_access("to_rsp", 0, 1, 3'b010, 32'h8000_0044, 32'h5555_AAAA, 32'h0,         1, -1, 0);
    run_access("buserr", 1, 0, 3'b001, 32'h8000_0006, 32'h0,         32'h1234_5678, 0, 2, 1);
    run_access("lhu",    1, 0, 3'b101, 32'h8000_0006, 32'h0,         32'hF00D_8001, 0, 1, 0);

    // Reset asserted mid-transaction, with the memory still owing a response.
    load = 1'b1; store = 1'b0; funct3 = 3'b010; addr = 32'h8000_0020; wdata = 32'h0;
    @(negedge clk);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    #1;
    chk("rst_mid:in_resp", busy, 1);
    #1;
    rst_n = 1'b0; load = 1'b0;
    #1;
    chk("rst_mid:busy", busy, 0);
    chk("rst_mid:rdata", rdata, 0);
    chk("rst_mid:err", err, 0);
    chk("rst_mid:req_valid", bus.mem_req_valid, 0);
    chk("rst_mid:mem_addr", bus.mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_access("sw_after_rst", 0, 1, 3'b010, 32'h8000_0100, 32'hCAFE_F00D, 32'h0, 0, 1, 0);

    for (int i = 0; i < 120; i++) begin
      kind = $urandom_range(0, 9);
      ld   = (kind <= 4) || (kind == 9);
      st   = (kind >= 5);
      f3   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = ld ? (($urandom_range(0, 1) != 0) ? 3'b100 : 3'b000) | 3'($urandom_range(0, 2))
                                             : 3'($urandom_range(0, 2));
      a    = $urandom;
      if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
      mode = $urandom_range(0, 11);
      rdy  = (mode == 10) ? -1 : $urandom_range(0, 2);
      rsp  = (mode == 11) ? -1 : $urandom_range(1, 3);
      rerr = ($urandom_range(0, 5) == 0);
      run_access("rnd", ld, st, f3, a, $urandom, $urandom, rdy, rsp, rerr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
